deserializer: RTL and testbench



---
 rtl/deserializer.sv | 132 +++++++++++++
 tb/tb_deserializer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/deserializer.sv
// Serial frame receiver: captures WIDTH-bit MSB-first frames after a Start marker and presents
// them through a valid/ready holding register. Optional DESERIALIZER_PATTERN_CHECK_EN macro.
module deserializer #(
  parameter int unsigned WIDTH       = 27,
  parameter int unsigned START_DELAY = 0,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 ClkOut,
  input  logic                 Reset,
  input  logic                 DataIn,
  input  logic                 Start,
  input  logic                 EnTestPattern,
  input  logic                 DataOutReady,
  output logic [WIDTH-1:0]     DataOut,
  output logic                 DataOutValid,
  output logic                 Busy,
  output logic [CNT_WIDTH-1:0] FrameCnt,
  output logic [7:0]           OverflowCnt,
  output logic                 AbortFlag
`ifdef DESERIALIZER_PATTERN_CHECK_EN
  ,
  output logic [CNT_WIDTH-1:0] PatternErrCnt,
  output logic                 PatternOk
`endif
);

  localparam int unsigned BitW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [BitW-1:0] LastBit = BitW'(WIDTH - 1);
  localparam logic [3:0] DelayInit = 4'(START_DELAY);

  if (WIDTH < 2) begin : g_width_min
    $error("deserializer: WIDTH must be at least 2");
  end
  if (START_DELAY > 15) begin : g_delay_range
    $error("deserializer: START_DELAY must be in 0..15");
  end

  typedef enum logic [1:0] {StIdle, StWait, StShift} state_e;

  state_e           state_q;
  logic [WIDTH-2:0] sr_q;
  logic [BitW-1:0]  bit_cnt_q;
  logic [3:0]       dly_q;

  logic [WIDTH-1:0] word;
  logic             last_sample;
  logic             load_word;
  logic             drop_word;

  // The completing word includes the bit being sampled on this edge.
  assign word        = {sr_q, DataIn};
  assign last_sample = (state_q == StShift) && (bit_cnt_q == LastBit);
  assign load_word   = last_sample && (!DataOutValid || DataOutReady);
  assign drop_word   = last_sample && DataOutValid && !DataOutReady;
  assign Busy        = (state_q != StIdle);

  always_ff @(posedge ClkOut) begin
    if (Reset) begin
      state_q      <= StIdle;
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      dly_q        <= '0;
      DataOut      <= '0;
      DataOutValid <= 1'b0;
      FrameCnt     <= '0;
      OverflowCnt  <= '0;
      AbortFlag    <= 1'b0;
    end else begin
      if (Start) begin
        // A Start on the final sample chains frames; anywhere else mid-frame it aborts.
        state_q   <= (START_DELAY > 0) ? StWait : StShift;
        dly_q     <= DelayInit;
        bit_cnt_q <= '0;
        sr_q      <= '0;
        if (Busy && !last_sample) AbortFlag <= 1'b1;
      end else begin
        unique case (state_q)
          StWait: begin
            if (dly_q == 4'd1) state_q <= StShift;
            else               dly_q   <= dly_q - 4'd1;
          end
          StShift: begin
            sr_q <= word[WIDTH-2:0];
            if (last_sample) begin
              state_q   <= StIdle;
              bit_cnt_q <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + BitW'(1);
            end
          end
          default: ;
        endcase
      end

      if (load_word) begin
        DataOut      <= word;
        DataOutValid <= 1'b1;
      end else if (DataOutValid && DataOutReady) begin
        DataOutValid <= 1'b0;
      end

      if (drop_word && (OverflowCnt != 8'hFF)) OverflowCnt <= OverflowCnt + 8'd1;
      if (last_sample) FrameCnt <= FrameCnt + CNT_WIDTH'(1);
    end
  end

`ifdef DESERIALIZER_PATTERN_CHECK_EN
  localparam logic [WIDTH-1:0] TestPattern = WIDTH'(27'h4AACC0F);

  if (WIDTH != 27) begin : g_pattern_width
    $error("deserializer: pattern check requires WIDTH == 27");
  end

  always_ff @(posedge ClkOut) begin
    if (Reset) begin
      PatternErrCnt <= '0;
      PatternOk     <= 1'b0;
    end else if (last_sample && EnTestPattern) begin
      if (word == TestPattern) begin
        PatternOk <= 1'b1;
      end else begin
        PatternOk <= 1'b0;
        if (PatternErrCnt != '1) PatternErrCnt <= PatternErrCnt + CNT_WIDTH'(1);
      end
    end
  end
`else
  logic unused_en_test_pattern;
  assign unused_en_test_pattern = EnTestPattern;
`endif

endmodule

// File: tb/tb_deserializer.sv
// Bench for deserializer: two instances (START_DELAY 0 and 3) driven with random and directed
// frames, checked against a transaction-level model and a delivered-word scoreboard.
module tb_deserializer;

  localparam logic [26:0] Pat = 27'h4AACC0F;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ready, en_tp;
  logic        start [2];
  logic        din   [2];
  logic [26:0] dout  [2];
  logic        vld   [2];
  logic        busy  [2];
  logic        abort [2];
  logic [15:0] fcnt  [2];
  logic [7:0]  ovf   [2];
`ifdef DESERIALIZER_PATTERN_CHECK_EN
  logic [15:0] perr  [2];
  logic        pok   [2];
`endif

  for (genvar g = 0; g < 2; g++) begin : g_dut
    deserializer #(.WIDTH(27), .START_DELAY(g * 3), .CNT_WIDTH(16)) u_dut (
      .ClkOut       (clk),
      .Reset        (rst),
      .DataIn       (din[g]),
      .Start        (start[g]),
      .EnTestPattern(en_tp),
      .DataOutReady (ready),
      .DataOut      (dout[g]),
      .DataOutValid (vld[g]),
      .Busy         (busy[g]),
      .FrameCnt     (fcnt[g]),
      .OverflowCnt  (ovf[g]),
      .AbortFlag    (abort[g])
`ifdef DESERIALIZER_PATTERN_CHECK_EN
      ,
      .PatternErrCnt(perr[g]),
      .PatternOk    (pok[g])
`endif
    );
  end

  int vectors = 0;
  int miscompares = 0;

  // Model: expected holding contents, counters and the words that must be handed over.
  logic [26:0] m_hold   [2];
  bit          m_vld    [2];
  logic [15:0] m_frames [2];
  int          m_ovf    [2];
  bit          m_abort  [2];
  logic [15:0] m_err;
  bit          m_ok;
  logic [26:0] exp0 [$], exp1 [$], rx0 [$], rx1 [$];

  always @(posedge clk) begin
    if (!rst) begin
      if (vld[0] && ready) rx0.push_back(dout[0]);
      if (vld[1] && ready) rx1.push_back(dout[1]);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int s, input logic [26:0] w);
    if (s == 0) exp0.push_back(w);
    else        exp1.push_back(w);
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_hold[s] = '0; m_vld[s] = 0; m_frames[s] = '0; m_ovf[s] = 0; m_abort[s] = 0;
    end
    m_err = '0;
    m_ok  = 0;
  endtask

  task automatic model_done(input int s, input logic [26:0] w);
    m_frames[s] = m_frames[s] + 16'd1;
    if (ready) begin
      push(s, w);
      m_hold[s] = w;
    end else if (!m_vld[s]) begin
      m_hold[s] = w;
      m_vld[s]  = 1;
    end else if (m_ovf[s] < 255) begin
      m_ovf[s]++;
    end
    if (s == 0 && en_tp) begin
      if (w == Pat) m_ok = 1;
      else begin
        m_ok = 0;
        if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
      end
    end
  endtask

  task automatic set_ready(input logic v);
    @(negedge clk);
    ready = v;
    if (v) begin
      for (int s = 0; s < 2; s++) begin
        if (m_vld[s]) begin
          push(s, m_hold[s]);
          m_vld[s] = 0;
        end
      end
    end
  endtask

  // Drives Start (unless already raised) and the first nbits of w, MSB first.
  task automatic frame(input int s, input logic [26:0] w, input bit pre, input bit chain,
                       input int nbits);
    if (!pre) begin
      @(negedge clk);
      start[s] = 1'b1;
    end
    @(negedge clk);
    start[s] = 1'b0;
    repeat (s * 3) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i != 0) @(negedge clk);
      din[s] = w[26-i];
    end
    if (chain) start[s] = 1'b1;
  endtask

  task automatic send(input int s, input logic [26:0] w);
    frame(s, w, 0, 0, 27);
    @(negedge clk);
    model_done(s, w);
  endtask

  task automatic check_state(input int s, input string tag);
    chk({tag, "_dout"}, dout[s], m_hold[s]);
    chk({tag, "_frames"}, fcnt[s], m_frames[s]);
    chk({tag, "_ovf"}, ovf[s], m_ovf[s]);
    chk({tag, "_abort"}, abort[s], m_abort[s]);
    chk({tag, "_busy"}, busy[s], 0);
`ifdef DESERIALIZER_PATTERN_CHECK_EN
    if (s == 0) begin
      chk({tag, "_pok"}, pok[0], m_ok);
      chk({tag, "_perr"}, perr[0], m_err);
    end
`endif
  endtask

  task automatic chk_q(input int s);
    logic [26:0] e [$];
    logic [26:0] r [$];
    if (s == 0) begin
      e = exp0; r = rx0; exp0.delete(); rx0.delete();
    end else begin
      e = exp1; r = rx1; exp1.delete(); rx1.delete();
    end
    chk($sformatf("q%0d_size", s), r.size(), e.size());
    for (int i = 0; i < e.size() && i < r.size(); i++)
      chk($sformatf("q%0d_word%0d", s, i), r[i], e[i]);
  endtask

  initial begin
    logic [26:0] w, w2;
    rst = 1'b1; ready = 1'b1; en_tp = 1'b0;
    for (int s = 0; s < 2; s++) begin
      start[s] = 1'b0;
      din[s]   = 1'b0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check_state(s, $sformatf("rst%0d", s));
      chk($sformatf("rst%0d_vld", s), vld[s], 0);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Basic frame with START_DELAY 0: valid for exactly one cycle with ready high.
    send(0, 27'h1234567);
    chk("t1_vld", vld[0], 1);
    chk("t1_word", dout[0], 27'h1234567);
    check_state(0, "t1");
    @(negedge clk);
    chk("t1_vld_clr", vld[0], 0);

    for (int k = 0; k < 4; k++) begin
      w = 27'($urandom);
      send(0, w);
      check_state(0, $sformatf("rnd%0d", k));
    end

    // START_DELAY 3, second Start on the last sample of the first frame.
    w  = 27'($urandom);
    w2 = 27'($urandom);
    frame(1, w, 0, 1, 27);
    model_done(1, w);
    frame(1, w2, 1, 0, 27);
    @(negedge clk);
    model_done(1, w2);
    check_state(1, "t2");
    @(negedge clk);
    chk_q(1);

    for (int k = 0; k < 12; k++) begin
      set_ready(1'($urandom_range(0, 1)));
      w = 27'($urandom);
      send(0, w);
      chk($sformatf("rr%0d_vld", k), vld[0], 1);
      check_state(0, $sformatf("rr%0d", k));
    end
    set_ready(1'b1);

    // Holding register full: later words dropped and counted.
    set_ready(1'b0);
    send(0, 27'h0000001);
    send(0, 27'h0000002);
    send(0, 27'h0000003);
    chk("t3_hold", dout[0], 27'h0000001);
    check_state(0, "t3");
    set_ready(1'b1);
    @(negedge clk);
    chk("t3_vld_clr", vld[0], 0);

    set_ready(1'b0);
    for (int k = 0; k < 257; k++) send(0, 27'($urandom));
    chk("sat_ovf", ovf[0], 255);
    check_state(0, "sat");
    set_ready(1'b1);
    @(negedge clk);

    // Abort: Start mid-frame, then a complete frame.
    frame(0, 27'($urandom), 0, 0, 10);
    chk("t4_busy", busy[0], 1);
    send(0, 27'h7FFFFFF);
    m_abort[0] = 1;
    check_state(0, "t4");
    check_state(1, "t4b");
    @(negedge clk);
    chk_q(0);
    chk_q(1);

    // Reset in the middle of a frame, then a clean frame.
    frame(0, 27'($urandom), 0, 0, 20);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_state(0, "t5_rst");
    chk("t5_vld", vld[0], 0);
    send(0, 27'h0ABCDEF);
    check_state(0, "t5");
    chk("t5_frames1", fcnt[0], 1);

`ifdef DESERIALIZER_PATTERN_CHECK_EN
    en_tp = 1'b1;
    send(0, Pat);
    check_state(0, "p1");
    send(0, 27'h4AACC0E);
    check_state(0, "p2");
    chk("p2_perr1", perr[0], 1);
    en_tp = 1'b0;
    send(0, 27'h0000000);
    check_state(0, "p3");
    en_tp = 1'b1;
    send(0, Pat);
    check_state(0, "p4");
    en_tp = 1'b0;
`endif
    @(negedge clk);
    chk_q(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
